alu: RTL and testbench
======================

Name: alu

Overview:
- Arithmetic/logic unit for the single-cycle ARMv4-subset core. Executes ADD, SUB, AND and ORR on two WIDTH-bit operands and produces a result plus NZCV status flags.
- Result and live flags are combinational, so they are usable in the same cycle by the datapath.
- Holds the architectural NZCV status register, updated on the clock under two independent write enables driven by the controller.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  system clock; the flag register updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears the flag register.
- a  input  WIDTH  operand A (SrcA).
- b  input  WIDTH  operand B (SrcB).
- alu_control  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- flag_w  input  2  flag write enables: [1] updates N,Z; [0] updates C,V.
- result  output  WIDTH  combinational operation result.
- alu_flags  output  4  combinational flags {N,Z,C,V} of the current operation.
- flags  output  4  registered status flags {N,Z,C,V}.

Behaviour:
- Operations (combinational, zero latency):
  - ADD: sum = a + b, computed with a WIDTH+1-bit adder.
  - SUB: sum = a + ~b + 1, i.e. a - b using the same adder with b inverted and carry-in 1.
  - AND: a & b.
  - ORR: a | b.
- result = sum for 00/01; bitwise result for 10/11.
- N = result[WIDTH-1].
- Z = 1 when result == 0; valid for all four operations.
- C:
  - For ADD/SUB: C = carry out of bit WIDTH-1 of the adder.
  - SUB uses ARM convention: C=1 means no borrow (a >= b unsigned).
  - For AND/ORR: C = 0.
- V:
  - For ADD/SUB: V = ~alu_control[1] & (a[MSB] ^ sum[MSB]) & ~(alu_control[0] ^ a[MSB] ^ b[MSB]). This is signed overflow.
  - For AND/ORR: V = 0.
- alu_flags = {N,Z,C,V}; all bits defined for every alu_control value (no X outputs).
- Flag register:
  - 4-bit register.
  - On reset asserted: flags = 4'b0000 immediately, regardless of clk.
  - While reset is high, clock edges are ignored.
  - On posedge clk with reset low:
    - if flag_w[1]: flags[3:2] <= alu_flags[3:2]
    - if flag_w[0]: flags[1:0] <= alu_flags[1:0]
    - unselected halves hold their value.
  - flag_w = 00: flags hold.
  - flag_w = 11: all four flags update.
  - flag_w = 01 (C,V only) is legal and honoured, though the controller never issues it.
- result and alu_flags do not depend on clk, reset or flag_w; reset does not force them.
- No other state, no handshakes; inputs are sampled only at the clock edge for the flag register.

Test Plan:
- ADD a=0xFFFFFFFF, b=0x00000001 -> result=0x00000000, alu_flags=0110 (Z=1, C=1, V=0). With flag_w=11, after posedge flags=0110.
- ADD a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, alu_flags=1001 (N=1, V=1, C=0). SUB a=0x80000000, b=1 -> 0x7FFFFFFF, alu_flags=0011.
- SUB a=5, b=5 -> result=0, alu_flags=0110. SUB a=3, b=5 -> result=0xFFFFFFFE, alu_flags=1000 (C=0, borrow).
- AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0, alu_flags=0000. ORR 0x0 | 0x0 -> 0, alu_flags=0100. Carry-generating operands under AND/ORR still give C=0 and V=0.
- Flag enables: preload flags=0110. Then apply SUB 3-5 with flag_w=10 -> after posedge flags=1010 (N,Z updated; C,V held). Apply flag_w=00 with any operation -> flags unchanged.
- Reset: set flags=1111, assert reset between clock edges -> flags=0000 immediately. Keep flag_w=11 with reset high for 2 edges -> flags stay 0000. Release reset -> next edge loads alu_flags.

Source files
------------

// File: rtl/alu.sv
// alu: ADD/SUB/AND/ORR datapath ALU with live NZCV flags and a
// registered NZCV status register under split write enables.
//
// Ports:
//   clk          flag register clock (rising edge)
//   reset        async active-high, clears the flag register
//   a, b         WIDTH-bit operands (SrcA, SrcB)
//   alu_control  00 ADD, 01 SUB, 10 AND, 11 ORR
//   flag_w       [1] writes N,Z  [0] writes C,V
//   result       combinational operation result
//   alu_flags    combinational {N,Z,C,V} of the current op
//   flags        registered {N,Z,C,V}
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       alu_control,
  input  logic [1:0]       flag_w,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;

  logic             sub;
  logic             logic_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             n_f;
  logic             z_f;
  logic             c_f;
  logic             v_f;
  logic [3:0]       flags_q;
  logic [3:0]       flags_d;

  assign sub      = alu_control[0];
  assign logic_op = alu_control[1];

  // SUB reuses the adder: a + ~b + 1, so the carry-out
  // is the ARM "no borrow" flag directly.
  assign b_eff = sub ? ~b : b;
  assign sum   = {1'b0, a}
               + {1'b0, b_eff}
               + {{WIDTH{1'b0}}, sub};

  always_comb begin
    res = sum[MSB:0];
    unique case (alu_control)
      2'b00:   res = sum[MSB:0];
      2'b01:   res = sum[MSB:0];
      2'b10:   res = a & b;
      2'b11:   res = a | b;
      default: res = sum[MSB:0];
    endcase
  end

  assign result = res;

  assign n_f = res[MSB];
  assign z_f = (res == '0);
  assign c_f = ~logic_op & sum[WIDTH];

  // Overflow when the operands (b taken as effectively
  // added) share a sign and the sum's sign differs.
  assign v_f = ~logic_op
             & (a[MSB] ^ sum[MSB])
             & ~(sub ^ a[MSB] ^ b[MSB]);

  assign alu_flags = {n_f, z_f, c_f, v_f};

  always_comb begin
    flags_d = flags_q;
    if (flag_w[1]) begin
      flags_d[3:2] = alu_flags[3:2];
    end
    if (flag_w[0]) begin
      flags_d[1:0] = alu_flags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vector table for the combinational ALU plus
// hand sequences for the flag register enables and reset.
module tb_alu;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   alu_control;
  logic [1:0]   flag_w;
  logic [W-1:0] result;
  logic [3:0]   alu_flags;
  logic [3:0]   flags;

  int checks;
  int errors;

  alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .flag_w      (flag_w),
    .result      (result),
    .alu_flags   (alu_flags),
    .flags       (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] exp_res;
    logic [3:0]   exp_flg;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op,
                       input logic [W-1:0] va,
                       input logic [W-1:0] vb,
                       input logic [1:0] fw);
    alu_control = op;
    a = va;
    b = vb;
    flag_w = fw;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{"add_wrap",  2'b00, 32'hFFFFFFFF, 32'h00000001,
                 32'h00000000, 4'b0110};
    vecs[1]  = '{"add_ovf",   2'b00, 32'h7FFFFFFF, 32'h00000001,
                 32'h80000000, 4'b1001};
    vecs[2]  = '{"sub_ovf",   2'b01, 32'h80000000, 32'h00000001,
                 32'h7FFFFFFF, 4'b0011};
    vecs[3]  = '{"sub_eq",    2'b01, 32'h00000005, 32'h00000005,
                 32'h00000000, 4'b0110};
    vecs[4]  = '{"sub_brw",   2'b01, 32'h00000003, 32'h00000005,
                 32'hFFFFFFFE, 4'b1000};
    vecs[5]  = '{"and_mix",   2'b10, 32'hF0F0F0F0, 32'h0FF00FF0,
                 32'h00F000F0, 4'b0000};
    vecs[6]  = '{"orr_zero",  2'b11, 32'h00000000, 32'h00000000,
                 32'h00000000, 4'b0100};
    vecs[7]  = '{"and_carry", 2'b10, 32'hFFFFFFFF, 32'h00000001,
                 32'h00000001, 4'b0000};
    vecs[8]  = '{"orr_neg",   2'b11, 32'h80000000, 32'h80000000,
                 32'h80000000, 4'b1000};
    vecs[9]  = '{"add_negov", 2'b00, 32'h80000000, 32'h80000000,
                 32'h00000000, 4'b0111};
    vecs[10] = '{"sub_0m1",   2'b01, 32'h00000000, 32'h00000001,
                 32'hFFFFFFFF, 4'b1000};
    vecs[11] = '{"add_plain", 2'b00, 32'h12345678, 32'h11111111,
                 32'h23456789, 4'b0000};

    // Reset state, and reset must not force the combinational path.
    reset = 1'b1;
    drive(2'b00, 32'd1, 32'd2, 2'b11);
    #2;
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_result", result, 32'd3);
    @(posedge clk);
    #1;
    chk("rst_hold_flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    flag_w = 2'b00;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].va, vecs[i].vb, 2'b00);
      #1;
      chk({vecs[i].name, "_res"}, result, vecs[i].exp_res);
      chk({vecs[i].name, "_flg"}, {28'd0, alu_flags},
          {28'd0, vecs[i].exp_flg});
    end
    @(posedge clk);
    #1;
    chk("fw00_after_table", {28'd0, flags}, 32'd0);

    // Preload 0110.
    @(negedge clk);
    drive(2'b00, 32'hFFFFFFFF, 32'h1, 2'b11);
    @(posedge clk);
    #1;
    chk("preload", {28'd0, flags}, 32'h6);

    // N,Z only from SUB 3-5 (1000): expect 10 | 10.
    @(negedge clk);
    drive(2'b01, 32'd3, 32'd5, 2'b10);
    @(posedge clk);
    #1;
    chk("fw10", {28'd0, flags}, 32'hA);

    // flag_w=00 holds.
    @(negedge clk);
    drive(2'b00, 32'h7FFFFFFF, 32'h1, 2'b00);
    @(posedge clk);
    #1;
    chk("fw00_hold", {28'd0, flags}, 32'hA);

    // C,V only from SUB 0x80000000-1 (0011): expect 10 | 11.
    @(negedge clk);
    drive(2'b01, 32'h80000000, 32'h1, 2'b01);
    @(posedge clk);
    #1;
    chk("fw01", {28'd0, flags}, 32'hB);

    // Async reset between edges clears immediately.
    @(negedge clk);
    drive(2'b00, 32'h7FFFFFFF, 32'h1, 2'b11);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst", {28'd0, flags}, 32'd0);
    chk("rst_no_force", {28'd0, alu_flags}, 32'h9);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_edges_ign", {28'd0, flags}, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_load", {28'd0, flags}, 32'h9);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
